// File: rtl/hazard_scoreboard_pkg.sv
// Constants shared by the pipeline hazard/forwarding logic.
// Register-index width, the r0 index and the forwarding source codes.
package hazard_scoreboard_pkg;

  localparam int NB_REG = 5;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    FROM_ID_EX  = 2'd0,
    FROM_EX_MEM = 2'd1,
    FROM_MEM_WB = 2'd2
  } fwd_src_e;

endpackage

// File: rtl/hazard_scoreboard_tag_stage.sv
// One destination-tag slot: holds {rd, wr_en, mem_read}, loads the incoming
// tag or a bubble on each enabled edge, and clears asynchronously.
module hazard_scoreboard_tag_stage
  import hazard_scoreboard_pkg::*;
#(
  parameter int NB_REG = hazard_scoreboard_pkg::NB_REG
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_load,
  input  logic [NB_REG-1:0] i_rd,
  input  logic              i_wr_en,
  input  logic              i_mem_read,
  output logic [NB_REG-1:0] o_rd,
  output logic              o_wr_en,
  output logic              o_mem_read
);

  logic [NB_REG-1:0] rd_q, rd_d;
  logic              wr_en_q, wr_en_d;
  logic              mem_read_q, mem_read_d;

  // A bubble is an all-zero tag so it can never match a consumer.
  always_comb begin
    rd_d       = '0;
    wr_en_d    = 1'b0;
    mem_read_d = 1'b0;
    if (i_load) begin
      rd_d       = i_rd;
      wr_en_d    = i_wr_en;
      mem_read_d = i_mem_read;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_q       <= '0;
      wr_en_q    <= 1'b0;
      mem_read_q <= 1'b0;
    end else if (i_enable) begin
      rd_q       <= rd_d;
      wr_en_q    <= wr_en_d;
      mem_read_q <= mem_read_d;
    end
  end

  assign o_rd       = rd_q;
  assign o_wr_en    = wr_en_q;
  assign o_mem_read = mem_read_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Destination-tag tracker for the ID/EX, EX/MEM and MEM/WB slots, with
// load-use stall detection and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NB_REG = hazard_scoreboard_pkg::NB_REG,
  parameter int NB_CNT = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic              i_id_rt_used,
  input  logic [NB_REG-1:0] i_id_rd,
  input  logic              i_id_wr_en,
  input  logic              i_id_mem_read,
  output logic              o_stall,
  output logic [NB_REG-1:0] o_id_ex_rd,
  output logic              o_id_ex_wr_en,
  output logic [NB_REG-1:0] o_ex_mem_rd,
  output logic              o_ex_mem_wr_en,
  output logic [NB_REG-1:0] o_mem_wb_rd,
  output logic              o_mem_wb_wr_en,
  output logic [NB_CNT-1:0] o_stall_count
);

  localparam logic [NB_REG-1:0] ZERO_TAG = NB_REG'(ZERO_REG);

  logic              id_wr_en;
  logic              id_ex_load;
  logic              id_ex_mem_read;
  logic              ex_mem_mem_read;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  // Writes to r0 are discarded here so r0 never shows up as a live tag.
  assign id_wr_en = i_id_wr_en & (i_id_rd != ZERO_TAG);

  assign o_stall = i_id_valid & id_ex_mem_read & o_id_ex_wr_en &
                   (o_id_ex_rd != ZERO_TAG) &
                   ((o_id_ex_rd == i_id_rs) |
                    (i_id_rt_used & (o_id_ex_rd == i_id_rt)));

  assign id_ex_load = i_id_valid & ~i_flush & ~o_stall;

  hazard_scoreboard_tag_stage #(.NB_REG(NB_REG)) u_id_ex (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_load     (id_ex_load),
    .i_rd       (i_id_rd),
    .i_wr_en    (id_wr_en),
    .i_mem_read (i_id_mem_read),
    .o_rd       (o_id_ex_rd),
    .o_wr_en    (o_id_ex_wr_en),
    .o_mem_read (id_ex_mem_read)
  );

  hazard_scoreboard_tag_stage #(.NB_REG(NB_REG)) u_ex_mem (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_load     (1'b1),
    .i_rd       (o_id_ex_rd),
    .i_wr_en    (o_id_ex_wr_en),
    .i_mem_read (id_ex_mem_read),
    .o_rd       (o_ex_mem_rd),
    .o_wr_en    (o_ex_mem_wr_en),
    .o_mem_read (ex_mem_mem_read)
  );

  hazard_scoreboard_tag_stage #(.NB_REG(NB_REG)) u_mem_wb (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_load     (1'b1),
    .i_rd       (o_ex_mem_rd),
    .i_wr_en    (o_ex_mem_wr_en),
    .i_mem_read (ex_mem_mem_read),
    .o_rd       (o_mem_wb_rd),
    .o_wr_en    (o_mem_wb_wr_en),
    .o_mem_read ()
  );

  always_comb begin
    cnt_d = cnt_q;
    if (o_stall && (cnt_q != {NB_CNT{1'b1}}))
      cnt_d = cnt_q + NB_CNT'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      cnt_q <= '0;
    else if (i_enable)
      cnt_q <= cnt_d;
  end

  assign o_stall_count = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Sequential destination-tag tracker for the 5-stage MIPS pipeline. It is the producer side of the operand-bypass interface: it accepts the decoded write intent of the instruction in ID and advances it through ID/EX, EX/MEM and MEM/WB slots. It drives the rd/write-enable tags that the forwarding logic consumes, and it generates the load-use stall and bubble. It sits beside the ID stage and is clocked with the pipeline registers.

## Interface
Parameters:
- NB_REG, `NB_REG (5), register-index width
- NB_CNT, 16, stall-counter width

Ports:
- i_clock  in  1  pipeline clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  pipeline advance enable (debug step); 0 freezes all state
- i_flush  in  1  branch/jump taken; kills the instruction entering ID/EX
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs  in  NB_REG  source register rs of ID instruction
- i_id_rt  in  NB_REG  source register rt of ID instruction
- i_id_rt_used  in  1  instruction reads rt (R-type, store, beq/bne)
- i_id_rd  in  NB_REG  resolved destination register (rd, rt or 31)
- i_id_wr_en  in  1  instruction writes the register file
- i_id_mem_read  in  1  instruction is a load
- o_stall  out  1  hold PC and IF/ID; combinational
- o_id_ex_rd  out  NB_REG  tag in ID/EX slot
- o_id_ex_wr_en  out  1
- o_ex_mem_rd  out  NB_REG  tag in EX/MEM slot (to forwarding)
- o_ex_mem_wr_en  out  1
- o_mem_wb_rd  out  NB_REG  tag in MEM/WB slot (to forwarding)
- o_mem_wb_wr_en  out  1
- o_stall_count  out  NB_CNT  saturating count of stall cycles

## Operation
- Three slots (ID/EX, EX/MEM, MEM/WB). Each slot holds {rd, wr_en, mem_read}. Only the ID/EX slot uses mem_read; it is carried for observability.
- Load-use detect (combinational): o_stall = i_id_valid & id_ex.mem_read & id_ex.wr_en & (id_ex.rd != 0) & ((id_ex.rd == i_id_rs) | (i_id_rt_used & id_ex.rd == i_id_rt)).
- o_stall is gated by nothing else. It reflects current state even when i_enable=0 or i_flush=1.
- Write to r0 is a no-op for hazards. Slots store wr_en = i_id_wr_en & (i_id_rd != 0), so r0 never produces tags.
- Per-edge update, in priority order:
  1. reset low: all slots cleared (rd=0, wr_en=0, mem_read=0), o_stall_count=0.
  2. i_enable=0: all state holds.
  3. otherwise EX/MEM←ID/EX and MEM/WB←EX/MEM always. The old MEM/WB tag retires.
  4. ID/EX loads a bubble (all zero) if i_flush | o_stall | !i_id_valid. Otherwise it loads the ID fields.
- Flush and stall in the same cycle: a single bubble is inserted, and the stall counter still increments.
- o_stall_count increments on every enabled edge where o_stall=1. It saturates at all-ones and does not wrap.
- Back-to-back load-use resolves in exactly one stall cycle. After the bubble, the load sits in EX/MEM and is no longer mem_read-checked in ID/EX, so o_stall drops.

## Timing
- Every output is a register except o_stall. Reset values are all zero, and o_stall=0 after reset.
- Tag latency: an ID instruction accepted at edge N appears on o_id_ex_* after N, on o_ex_mem_* after N+1, and on o_mem_wb_* after N+2, assuming i_enable=1 throughout.
- Reset is asserted asynchronously and outputs clear immediately. Deassertion is synchronised externally; the block samples normally on the first edge after release.
- Reset mid-stall: the ID/EX load tag is lost, so o_stall falls in the same cycle.

## Structure
- The shared include holds NB_REG, ZERO_REG (5'd0) and the FROM_ID_EX/FROM_EX_MEM/FROM_MEM_WB codes. This block needs no new constants beyond ZERO_REG.
- Sub-module tag_stage: one slot register with enable, bubble/load select and async active-low clear. It is instantiated three times.
- Stall compare and saturating counter live in the top level.

## Test plan
- Reset: hold i_reset=0 for 3 cycles with random inputs. All tag outputs must be 0, o_stall=0 and o_stall_count=0.
- Tag pipeline: issue addu rd=8 (wr_en=1), then two NOPs. Expect o_id_ex_rd=8, then o_ex_mem_rd=8, then o_mem_wb_rd=8 on successive edges, with wr_en following. Issue rd=0 with wr_en=1: every wr_en output stays 0.
- Load-use: lw rd=9, then ID rs=9. Expect o_stall=1 for exactly one cycle, ID/EX holds a bubble, o_ex_mem_rd=9, and o_stall_count=1. Repeat with rt=9 and i_id_rt_used=0: no stall.
- Flush + stall: same as the load-use case with i_flush=1 on the stall cycle. Expect one bubble, the counter increments, and no double bubble.
- Enable freeze: i_enable=0 for 4 cycles mid-sequence. All tags and the counter hold, and o_stall still reflects the frozen state.
- Saturation: with NB_CNT=4, force 20 stall cycles. o_stall_count must stop at 15.
